// File: rtl/async_fifo_rd_ctrl.sv
// Read-domain controller of the dual-clock FIFO (clk_b only).
// Syncs the Gray write pointer, feeds a FWFT output register, returns Gray read pointer.
module async_fifo_rd_ctrl #(
    parameter  int FIFO_DEPTH = 8,
    parameter  int DATA_WIDTH = 64,
    localparam int AW         = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk_b,
    input  logic                  rst_b,
    input  logic [AW:0]           wptr_gray_async,
    output logic [AW:0]           rptr_gray,
    output logic [AW-1:0]         mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    input  logic                  rd_en,
    output logic                  empty,
    output logic [AW:0]           level
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("async_fifo_rd_ctrl: FIFO_DEPTH must be a power of two >= 2");
    end

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [AW:0] wsync_meta;
    logic [AW:0] wsync_gray;
    logic [AW:0] wsync_bin;
    logic [AW:0] rptr_bin;
    logic [AW:0] rptr_bin_inc;
    logic        mem_has_data;
    logic        fetch;

    // Two-flop synchronizer, nothing between the stages
    always_ff @(posedge clk_b) begin
        if (rst_b) begin
            wsync_meta <= '0;
            wsync_gray <= '0;
        end else begin
            wsync_meta <= wptr_gray_async;
            wsync_gray <= wsync_meta;
        end
    end

    assign wsync_bin    = gray2bin(wsync_gray);
    assign rptr_bin_inc = rptr_bin + 1'b1;
    assign mem_has_data = (wsync_gray != rptr_gray);
    assign fetch        = mem_has_data && (!valid || rd_en);

    // Fetch into the output register, or drop the head on a pop with nothing behind it
    always_ff @(posedge clk_b) begin
        if (rst_b) begin
            rptr_bin  <= '0;
            rptr_gray <= '0;
            valid     <= 1'b0;
            dout      <= '0;
        end else if (fetch) begin
            rptr_bin  <= rptr_bin_inc;
            rptr_gray <= bin2gray(rptr_bin_inc);
            valid     <= 1'b1;
            dout      <= mem_rdata;
        end else if (valid && rd_en) begin
            valid     <= 1'b0;
        end
    end

    assign mem_raddr = rptr_bin[AW-1:0];
    assign empty     = !valid;
    assign level     = (wsync_bin - rptr_bin) + {{AW{1'b0}}, valid};

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Bench for async_fifo_rd_ctrl: the bench plays write side and storage,
// and a count-based reference model predicts every output each edge.
module tb_async_fifo_rd_ctrl;

    localparam int DEPTH = 8;
    localparam int DW    = 64;
    localparam int AW    = 3;

    logic          clk_b = 1'b0;
    logic          rst_b;
    logic [AW:0]   wptr_gray_async;
    logic [AW:0]   rptr_gray;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] dout;
    logic          valid;
    logic          rd_en;
    logic          empty;
    logic [AW:0]   level;

    logic [DW-1:0] mem [DEPTH];

    int vec = 0;
    int err = 0;

    // model: wp = words written, rp = words taken out of storage
    int            wp, rp, s1, s2;
    bit            mv;
    logic [DW-1:0] mdout;
    logic [AW:0]   prev_g;
    bit            seen_wrap;

    always #5 clk_b = ~clk_b;

    assign mem_rdata = mem[mem_raddr];

    async_fifo_rd_ctrl #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk_b           (clk_b),
        .rst_b           (rst_b),
        .wptr_gray_async (wptr_gray_async),
        .rptr_gray       (rptr_gray),
        .mem_raddr       (mem_raddr),
        .mem_rdata       (mem_rdata),
        .dout            (dout),
        .valid           (valid),
        .rd_en           (rd_en),
        .empty           (empty),
        .level           (level)
    );

    function automatic logic [AW:0] g(input int b);
        logic [AW:0] x;
        x = b[AW:0];
        return x ^ (x >> 1);
    endfunction

    // one clk_b edge: advance model with pre-edge inputs, then check all outputs
    task automatic step();
        bit          has;
        bit          was_rst;
        logic [AW:0] exp_lvl;
        @(posedge clk_b);
        was_rst = rst_b;
        if (rst_b) begin
            s1 = 0; s2 = 0; rp = 0; mv = 0; mdout = '0;
        end else begin
            has = (s2 != (rp & 15));
            if (has && (!mv || rd_en)) begin
                mdout = mem[rp & 7];
                mv = 1;
                rp++;
            end else if (mv && rd_en) begin
                mv = 0;
            end
            s2 = s1;
            s1 = wp & 15;
        end
        #1;
        exp_lvl = 4'(((s2 - rp) & 15) + int'(mv));
        vec++;
        if (valid !== mv) begin
            err++; $display("FAIL valid: got %0b want %0b at %0t", valid, mv, $time);
        end
        vec++;
        if (empty !== !mv) begin
            err++; $display("FAIL empty: got %0b want %0b at %0t", empty, !mv, $time);
        end
        vec++;
        if (dout !== mdout) begin
            err++; $display("FAIL dout: got %h want %h at %0t", dout, mdout, $time);
        end
        vec++;
        if (rptr_gray !== g(rp)) begin
            err++; $display("FAIL rptr_gray: got %b want %b at %0t", rptr_gray, g(rp), $time);
        end
        vec++;
        if (mem_raddr !== 3'(rp & 7)) begin
            err++; $display("FAIL mem_raddr: got %0d want %0d at %0t", mem_raddr, rp & 7, $time);
        end
        vec++;
        if (level !== exp_lvl) begin
            err++; $display("FAIL level: got %0d want %0d at %0t", level, exp_lvl, $time);
        end
        if (!was_rst && rptr_gray !== prev_g) begin
            vec++;
            if ($countones(rptr_gray ^ prev_g) != 1) begin
                err++; $display("FAIL gray_step: got %b->%b want 1-bit step", prev_g, rptr_gray);
            end
            if (prev_g == 4'b1000 && rptr_gray == 4'b0000) seen_wrap = 1;
        end
        prev_g = rptr_gray;
    endtask

    task automatic push(input logic [DW-1:0] d);
        mem[wp & 7] = d;
        wp++;
        wptr_gray_async = g(wp);
    endtask

    task automatic test_reset();
        rst_b = 1; rd_en = 0;
        wptr_gray_async = 4'b0101;
        repeat (2) step();
        vec++;
        if (level !== 0 || valid !== 0 || empty !== 1 || dout !== '0) begin
            err++; $display("FAIL reset_outs: got lvl=%0d v=%0b e=%0b want 0/0/1", level, valid, empty);
        end
        rst_b = 0; wp = 0; wptr_gray_async = '0;
        repeat (3) step();
    endtask

    task automatic test_single();
        push(64'hA5);
        step(); step();
        vec++;
        if (valid !== 0) begin
            err++; $display("FAIL single_early: got valid=%0b want 0 after 2 edges", valid);
        end
        step();
        vec++;
        if (valid !== 1 || dout !== 64'hA5 || level !== 1 || rptr_gray !== 4'b0001) begin
            err++; $display("FAIL single: got v=%0b d=%h l=%0d g=%b want 1/a5/1/0001",
                            valid, dout, level, rptr_gray);
        end
        rd_en = 1; step();
        rd_en = 0; step();
    endtask

    task automatic test_stream();
        for (int i = 0; i < 8; i++) push(64'h10 + 64'(i));
        rd_en = 1;
        repeat (14) step();
        rd_en = 0;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 8; i++) push(64'h20 + 64'(i));
        repeat (6) step();
        vec++;
        if (level !== 8 || valid !== 1 || dout !== 64'h20) begin
            err++; $display("FAIL backpressure: got l=%0d v=%0b d=%h want 8/1/20", level, valid, dout);
        end
        rd_en = 1;
        repeat (10) step();
        rd_en = 0;
    endtask

    task automatic test_wrap();
        for (int c = 0; c < 90; c++) begin
            rd_en = ($urandom_range(0, 9) < 7);
            if ((wp - rp) < DEPTH && $urandom_range(0, 9) < 6)
                push({$urandom, $urandom});
            step();
        end
        rd_en = 1;
        repeat (14) step();
        vec++;
        if (!seen_wrap) begin
            err++; $display("FAIL wrap: got no 1000->0000 rptr_gray step, want one");
        end
    endtask

    task automatic test_underflow();
        logic [AW:0] g0;
        rd_en = 1;
        repeat (4) step();
        g0 = rptr_gray;
        repeat (5) step();
        vec++;
        if (valid !== 0 || rptr_gray !== g0 || level !== 0) begin
            err++; $display("FAIL underflow: got v=%0b g=%b l=%0d want 0/%b/0", valid, rptr_gray, level, g0);
        end
        rd_en = 0;
    endtask

    task automatic test_midreset();
        for (int i = 0; i < 5; i++) push(64'h40 + 64'(i));
        repeat (4) step();
        rst_b = 1;
        step();
        rst_b = 0; wp = 0; wptr_gray_async = '0;
        repeat (3) step();
        push(64'h77);
        repeat (3) step();
        vec++;
        if (dout !== 64'h77 || valid !== 1 || level !== 1) begin
            err++; $display("FAIL midreset: got d=%h v=%0b l=%0d want 77/1/1", dout, valid, level);
        end
    endtask

    initial begin
        wp = 0; rp = 0; s1 = 0; s2 = 0; mv = 0; mdout = '0;
        prev_g = '0; seen_wrap = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_wrap();
        test_underflow();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/async_fifo_rd_ctrl.md
# async_fifo_rd_ctrl

Read-domain half of the dual-clock FIFO, running entirely in the clk_b domain. It synchronizes the Gray-coded write pointer from the clk_a domain and decodes it to binary. It then fetches words from the shared storage array into a first-word-fall-through output register and returns a Gray-coded read pointer for the write side's full logic. It pairs with the write-domain controller and storage array, which live outside this block.

## Interface
- FIFO_DEPTH, 8: storage words; power of two, ≥2; any other value is an elaboration error.
- DATA_WIDTH, 64: word width.
- Derived: AW = $clog2(FIFO_DEPTH); pointers are AW+1 bits wide.

Ports:
- clk_b  in  1  read-domain clock; the only clock in this block.
- rst_b  in  1  reset; synchronous, active-high.
- wptr_gray_async  in  AW+1  Gray write pointer, registered in clk_a; asynchronous to clk_b.
- rptr_gray  out  AW+1  registered Gray read pointer, sent to the clk_a synchronizer.
- mem_raddr  out  AW  storage read address; storage read is combinational.
- mem_rdata  in  DATA_WIDTH  storage data at mem_raddr, same cycle.
- dout  out  DATA_WIDTH  head-of-queue word.
- valid  out  1  dout holds a word.
- rd_en  in  1  pop; acts only when valid=1.
- empty  out  1  equals !valid.
- level  out  AW+1  words held in storage and the output register, as seen by the read side.

## Operation
- Synchronizer: 2-flop chain on wptr_gray_async produces wsync_gray. No logic sits between the two flops.
- Decode: wsync_bin[i] = XOR of wsync_gray[AW:i].
- Read pointer:
  - rptr_bin is AW+1 bits; rptr_gray = rptr_bin ^ (rptr_bin >> 1), both registered.
  - mem_raddr = rptr_bin[AW-1:0].
- mem_has_data = (wsync_gray != rptr_gray).
- fetch = mem_has_data && (!valid || rd_en).
- Each edge:
  - If fetch: dout <= mem_rdata, valid <= 1, rptr_bin <= rptr_bin+1, rptr_gray <= gray(rptr_bin+1).
  - Else if valid && rd_en: valid <= 0; dout holds its last value.
  - rd_en while valid=0: ignored. No pointer change, no underflow.
- level = (wsync_bin − rptr_bin) mod 2^(AW+1), plus valid. Range 0..FIFO_DEPTH+1. This is combinational from registers.
- Wrap-around: pointers roll over from 2·FIFO_DEPTH−1 to 0. A single rptr_gray step always changes exactly one bit, including the rollover.
- State is implicit (valid × mem_has_data):
  - EMPTY (valid=0): fetches as soon as mem_has_data.
  - HOLD (valid=1, rd_en=0): no change.
  - STREAM (valid=1, rd_en=1, mem_has_data): pop and refill on the same edge.
  - DRAIN (valid=1, rd_en=1, !mem_has_data): goes to EMPTY.

## Timing
- Reset values, applied on the first clk_b edge with rst_b=1: sync chain 0, rptr_bin 0, rptr_gray 0, valid 0, dout 0, empty 1, level 0, mem_raddr 0.
- Reset mid-operation: all state clears on that edge and any in-flight word is discarded. The write side must be reset in the same window; resetting only one side is unsupported.
- Latency from wptr_gray_async change to valid=1: 3 clk_b edges (2 sync, 1 fetch), given a stable input before the first edge.
- Throughput: 1 word per cycle with rd_en held high, with no bubbles while mem_has_data.
- rptr_gray updates on the fetch edge. The write side sees a freed slot only after its own 2-flop sync.
- level and empty lag the true write pointer by the 2-cycle sync. The error is always conservative, never an overcount.

## Test plan
- Reset: drive rst_b=1 for 2 edges with wptr_gray_async=0101 -> all outputs 0, empty=1. After release, wptr_gray_async=0 keeps valid=0.
- Single word (DEPTH 8): wptr_gray_async 0000→0001, mem_rdata=0xA5 at addr 0 -> on 3rd edge valid=1, dout=0xA5, mem_raddr=1, rptr_gray=0001, level=1.
- Streaming: 8 words (0x10..0x17) available, rd_en=1 -> dout steps 0x10..0x17 on consecutive cycles, then valid=0 and empty=1 one edge after the last pop.
- Backpressure: 8 words available, rd_en=0 -> exactly one fetch (dout=word 0, rptr_bin=1), level=8, valid held. Raising rd_en drains the rest back-to-back.
- Wrap: push and pop 20 words -> rptr_gray passes 1000→0000 at binary 15→0, data stays in order, and every rptr_gray change is a 1-bit Hamming step.
- Underflow: rd_en=1 for 5 cycles while empty -> rptr_gray, dout and level unchanged, valid stays 0.
